// File: rtl/ung_pkg.sv
// ============================================================================
// Module      : ung_pkg
// Description : Shared types, mode constants and frame-length helper for the
//               multi-channel unary number generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ung_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ung_state_t;

    localparam logic UNG_MODE_LEAD  = 1'b0;
    localparam logic UNG_MODE_TRAIL = 1'b1;

    function automatic int unsigned ung_frame_len(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ung_channel.sv
// ============================================================================
// Module      : ung_channel
// Description : One unary lane; emits the registered stream bit for frame
//               cycle k in leading-ones or trailing-ones placement.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ung_channel #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value,
    input  logic             mode,
    input  logic [WIDTH-1:0] k,
    input  logic             run,
    output logic             bs
);
    import ung_pkg::*;

    localparam logic [WIDTH:0] c_FRAME_LEN = (WIDTH+1)'(ung_frame_len(WIDTH));

    logic [WIDTH:0] w_threshold;
    logic           w_bit;
    logic           r_bs;

    // Trailing threshold needs the extra bit so that value 0 maps to FRAME_LEN.
    always_comb begin
        w_threshold = c_FRAME_LEN - {1'b0, value};
        w_bit       = 1'b0;
        if (run) begin
            if (mode == UNG_MODE_TRAIL) begin
                w_bit = ({1'b0, k} >= w_threshold);
            end else begin
                w_bit = (k < value);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bs <= 1'b0;
        end else begin
            r_bs <= w_bit;
        end
    end

    assign bs = r_bs;

endmodule

`default_nettype wire

// File: rtl/ung_multi.sv
// ============================================================================
// Module      : ung_multi
// Description : CH-lane unary number generator sharing one 2^WIDTH frame
//               timer, with valid/ready load and frame status outputs.
//               Optional macro UNG_DOUBLE_BUFFER_EN adds a one-deep shadow
//               load register for gap-free back-to-back frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ung_multi #(
    parameter int WIDTH = 5,
    parameter int CH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH*WIDTH-1:0] in_data,
    input  logic                in_mode,
    output logic [CH-1:0]       bs_out,
    output logic                bs_valid,
    output logic                frame_start,
    output logic                frame_last,
    output logic                busy
);
    import ung_pkg::*;

    localparam int unsigned      c_FRAME_LEN = ung_frame_len(WIDTH);
    localparam logic [WIDTH-1:0] c_K_LAST    = WIDTH'(c_FRAME_LEN - 1);

    ung_state_t          r_state;
    ung_state_t          w_state_next;
    logic [WIDTH-1:0]    r_k;
    logic [CH*WIDTH-1:0] r_val;
    logic                r_mode;
    logic                r_in_ready;
    logic                r_bs_valid;
    logic                r_frame_start;
    logic                r_frame_last;

    logic                w_load;
    logic                w_last;
    logic                w_run;
    logic                w_frame_start_d;
    logic                w_frame_last_d;
    logic                w_ready_next;
    logic                w_act_from_in;

`ifdef UNG_DOUBLE_BUFFER_EN
    logic [CH*WIDTH-1:0] r_sh_val;
    logic                r_sh_mode;
    logic                r_sh_full;
    logic                w_act_from_sh;
    logic                w_sh_load;
    logic                w_sh_full_next;
`endif

    assign w_load = in_valid & r_in_ready;
    assign w_last = (r_k == c_K_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
`ifdef UNG_DOUBLE_BUFFER_EN
                    // A pending load (held or arriving now) keeps the frames contiguous.
                    if (!(r_sh_full || w_load)) begin
                        w_state_next = IDLE;
                    end
`else
                    w_state_next = IDLE;
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_run           = (r_state == RUN);
        w_frame_start_d = w_run && (r_k == '0);
        w_frame_last_d  = w_run && w_last;
`ifdef UNG_DOUBLE_BUFFER_EN
        w_act_from_sh   = w_run && w_last && r_sh_full;
        w_act_from_in   = w_load && (!w_run || (w_last && !r_sh_full));
        w_sh_load       = w_load && !w_act_from_in;
        w_sh_full_next  = w_sh_load || (r_sh_full && !w_act_from_sh);
        w_ready_next    = !w_sh_full_next;
`else
        w_act_from_in   = w_load;
        w_ready_next    = (w_state_next == IDLE);
`endif
    end

    // ------------------------------------------------------------------
    // Frame counter and active value registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k    <= '0;
            r_val  <= '0;
            r_mode <= UNG_MODE_LEAD;
        end else begin
            // Natural WIDTH-bit wrap returns k to 0 exactly at frame end.
            if (w_run) begin
                r_k <= r_k + 1'b1;
            end else if (w_load) begin
                r_k <= '0;
            end

            if (w_act_from_in) begin
                r_val  <= in_data;
                r_mode <= in_mode;
            end
`ifdef UNG_DOUBLE_BUFFER_EN
            else if (w_act_from_sh) begin
                r_val  <= r_sh_val;
                r_mode <= r_sh_mode;
            end
`endif
        end
    end

`ifdef UNG_DOUBLE_BUFFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_val  <= '0;
            r_sh_mode <= UNG_MODE_LEAD;
            r_sh_full <= 1'b0;
        end else begin
            r_sh_full <= w_sh_full_next;
            if (w_sh_load) begin
                r_sh_val  <= in_data;
                r_sh_mode <= in_mode;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registered status outputs, aligned with the lane bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_ready    <= 1'b0;
            r_bs_valid    <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_last  <= 1'b0;
        end else begin
            r_in_ready    <= w_ready_next;
            r_bs_valid    <= w_run;
            r_frame_start <= w_frame_start_d;
            r_frame_last  <= w_frame_last_d;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        ung_channel #(
            .WIDTH (WIDTH)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .value (r_val[c*WIDTH +: WIDTH]),
            .mode  (r_mode),
            .k     (r_k),
            .run   (w_run),
            .bs    (bs_out[c])
        );
    end

    assign in_ready    = r_in_ready;
    assign bs_valid    = r_bs_valid;
    assign busy        = r_bs_valid;
    assign frame_start = r_frame_start;
    assign frame_last  = r_frame_last;

endmodule

`default_nettype wire

// File: doc/ung_multi.md
Name: ung_multi

Overview:
- Multi-channel, parametrised unary number generator (UNG) for the stochastic-computing bit-stream path.
- Accepts CH binary values of WIDTH bits each through a valid/ready handshake.
- Emits one unary bit-stream per channel over a fixed frame of 2^WIDTH cycles; the number of 1s in channel c equals its loaded value.
- Adds two things the single-channel countdown generator lacks: leading-ones or trailing-ones placement, and frame framing/status outputs. It feeds the downstream SC arithmetic lanes.

Parameters:
WIDTH, 5, data precision m; frame length FRAME_LEN = 2^WIDTH cycles
CH, 4, number of independent channels sharing one frame timer

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input values present
in_ready  out  1  block can accept a load this cycle
in_data  in  CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
in_mode  in  1  0 = leading ones (1s first), 1 = trailing ones (1s last); sampled with the load
bs_out  out  CH  unary bit per channel, valid when bs_valid=1
bs_valid  out  1  a frame bit is being emitted
frame_start  out  1  high on frame cycle k=0
frame_last  out  1  high on frame cycle k=FRAME_LEN-1
busy  out  1  frame in progress (equals bs_valid)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; frame counter 0; channel values 0; bs_out=0; bs_valid=0; frame_start=0; frame_last=0; busy=0; in_ready=1 from the first cycle after reset release.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data and in_mode, clear k, go to RUN.
  - RUN: in_ready=0 (base build). k increments each cycle. At k=FRAME_LEN-1 go to IDLE.
- Latency: load accepted on edge t; first stream bit (k=0) is registered and visible after edge t+1. All outputs are registered.
- Per-channel bit at frame cycle k:
  - mode 0: bs_out[c] = (k < v_c)
  - mode 1: bs_out[c] = (k >= FRAME_LEN - v_c), computed in WIDTH+1 bits
- Ones count is exactly v_c; maximum is FRAME_LEN-1. v=0 gives all zeros in both modes.
- Frame counter is WIDTH bits. Its natural wrap from FRAME_LEN-1 to 0 coincides with frame end, so no extra compare width is needed.
- Back-to-back frames in the base build: one IDLE bubble between frames, i.e. one cycle with bs_valid=0.
- Outside RUN: bs_out=0 and frame_start=frame_last=0.
- in_valid while in_ready=0: ignored. The source must hold the data; nothing is latched.
- Reset asserted mid-frame: the frame is aborted immediately and all outputs go to their reset values. There is no partial-frame completion.
- in_data or in_mode changing during RUN has no effect; only the values latched at load are used.

Optional Feature:
UNG_DOUBLE_BUFFER_EN
- Defined:
  - A shadow register holds one pending (data, mode) load.
  - in_ready = shadow empty, in both IDLE and RUN.
  - At k=FRAME_LEN-1, if the shadow is full, it is transferred to the active registers and the block stays in RUN with k=0 next cycle. Frames run gap-free: frame_last is followed directly by frame_start.
  - A load and a transfer in the same cycle: the shadow takes the new load, the active registers take the old shadow.
  - A load in IDLE with the shadow empty goes straight to the active registers.
- Undefined: base behaviour exactly as above.

Decomposition:
- Package ung_pkg holds:
  - state enum {IDLE, RUN}
  - mode constants UNG_MODE_LEAD=0, UNG_MODE_TRAIL=1
  - a localparam function for FRAME_LEN from WIDTH
- Sub-module ung_channel (one per channel, generated CH times):
  - inputs: value, mode, k, run
  - output: registered bit
- The top level owns the FSM, frame counter, handshake and optional shadow.

Test Plan:
- Reset: WIDTH=5, CH=4. Assert rst=0 mid-idle and mid-frame (k=10) -> all outputs 0 asynchronously; in_ready=1 after release.
- Leading mode: load {31,16,1,0}, mode 0 -> 32 bs_valid cycles. Ch0 is 1 on k=0..30; ch1 is 1 on k=0..15; ch2 is 1 only on k=0; ch3 is all 0. frame_start at k=0, frame_last at k=31.
- Trailing mode: load {5,0,31,20}, mode 1 -> ch0 is 1 on k=27..31; ch2 is 1 on k=1..31; ch3 is 1 on k=12..31. Popcount per channel equals the loaded value.
- Handshake: hold in_valid=1 with changing data during RUN -> no reload. The next load is accepted only at the IDLE cycle, and one bubble cycle with bs_valid=0 is seen (base build).
- UNG_DOUBLE_BUFFER_EN: load A, then load B at k=3 -> in_ready drops after B. A's frame_last is immediately followed by B's frame_start. 64 consecutive bs_valid=1 cycles.
- Random: 200 random loads and modes; the scoreboard checks per-channel popcount and 1s placement against the mode.
